// File: rtl/button_pkg.sv
// Shared encodings and width helpers for the button conditioning block.
package button_pkg;

   typedef enum logic [1:0] {
      REL   = 2'd0,
      CHK_P = 2'd1,
      PRS   = 2'd2,
      CHK_R = 2'd3
   } db_state_t;

   typedef enum logic [1:0] {
      POR     = 2'd0,
      RUN     = 2'd1,
      BTN     = 2'd2,
      STRETCH = 2'd3
   } seq_state_t;

   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, press/release strobes.
// Optional hold counter and long-press strobe under BUTTON_LONG_PRESS_EN.
//
// state | meaning
// REL   | released, level_n = 1
// CHK_P | press seen, counting stable-low cycles
// PRS   | pressed, level_n = 0
// CHK_R | release seen, counting stable-high cycles
module btn_debounce_ch
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
`ifdef BUTTON_LONG_PRESS_EN
   , parameter int LONG_CYCLES = 25000000
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic level_n,
   output logic level_n_nxt,
   output logic press_stb,
   output logic release_stb,
   output logic long_stb
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_TC  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          sync_q1, sync_q2;
   db_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_d, release_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1     <= 1'b1;
         sync_q2     <= 1'b1;
         state_q     <= REL;
         cnt_q       <= '0;
         press_stb   <= 1'b0;
         release_stb <= 1'b0;
      end else begin
         sync_q1     <= btn_n;
         sync_q2     <= sync_q1;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         press_stb   <= press_d;
         release_stb <= release_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         REL: begin
            if (!sync_q2) begin
               state_d = CHK_P;
               cnt_d   = CNT_ONE;
            end
         end
         CHK_P: begin
            if (sync_q2) begin
               state_d = REL;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_TC) begin
               state_d = PRS;
               cnt_d   = '0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRS: begin
            if (sync_q2) begin
               state_d = CHK_R;
               cnt_d   = CNT_ONE;
            end
         end
         CHK_R: begin
            if (!sync_q2) begin
               state_d = PRS;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_TC) begin
               state_d   = REL;
               cnt_d     = '0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = REL;
            cnt_d   = '0;
         end
      endcase
   end

   assign level_n     = !((state_q == PRS) || (state_q == CHK_R));
   // look-ahead level lets the reset sequencer act on the same edge as the strobe
   assign level_n_nxt = !((state_d == PRS) || (state_d == CHK_R));

`ifdef BUTTON_LONG_PRESS_EN
   localparam int HW = cnt_width(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_TC  = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

   logic [HW-1:0] hold_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q   <= '0;
         long_stb <= 1'b0;
      end else begin
         long_stb <= (state_q == PRS) && (hold_q == HOLD_TC);
         if (state_q != PRS)
            hold_q <= '0;
         else if (hold_q != HOLD_MAX)
            hold_q <= hold_q + 1'b1;
      end
   end
`else
   assign long_stb = 1'b0;
`endif

endmodule

// File: rtl/button_reset_ctrl.sv
// Button conditioning top: per-channel debounce plus system reset sequencer.
// Optional long-press strobes are enabled with BUTTON_LONG_PRESS_EN.
//
// state   | meaning
// POR     | power-on hold, sys_rst_n = 0 for POR_CYCLES
// RUN     | system running, sys_rst_n = 1
// BTN     | reset button held, sys_rst_n = 0
// STRETCH | button released, sys_rst_n held 0 for RST_STRETCH
module button_reset_ctrl
   import button_pkg::*;
#(
   parameter int NUM_BTN         = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int POR_CYCLES      = 1000,
   parameter int RST_STRETCH     = 64,
   parameter int LONG_CYCLES     = 25000000
) (
   input  logic               clk25,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_n,
   output logic [NUM_BTN-1:0] btn_level_n,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               sys_rst_n,
   output logic [NUM_BTN-1:0] btn_long
);

   localparam int SW = cnt_width(max_int(POR_CYCLES, RST_STRETCH));
   localparam logic [SW-1:0] POR_TC = SW'(POR_CYCLES - 1);
   localparam logic [SW-1:0] STR_TC = SW'(RST_STRETCH - 1);

   logic [NUM_BTN-1:0] lvl_nxt;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_LONG_PRESS_EN
         , .LONG_CYCLES(LONG_CYCLES)
`endif
      ) u_ch (
         .clk         (clk25),
         .rst_n       (rst_n),
         .btn_n       (btn_n[i]),
         .level_n     (btn_level_n[i]),
         .level_n_nxt (lvl_nxt[i]),
         .press_stb   (btn_press[i]),
         .release_stb (btn_release[i]),
         .long_stb    (btn_long[i])
      );
   end

   // channels >= 1 never steer the sequencer; LONG_CYCLES only feeds the hold counters
   logic unused_cfg;
   assign unused_cfg = &{1'b0, lvl_nxt, (LONG_CYCLES > 0)};

   seq_state_t    seq_q, seq_d;
   logic [SW-1:0] scnt_q, scnt_d;

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         seq_q     <= POR;
         scnt_q    <= '0;
         sys_rst_n <= 1'b0;
      end else begin
         seq_q     <= seq_d;
         scnt_q    <= scnt_d;
         sys_rst_n <= (seq_d == RUN);
      end
   end

   always_comb begin
      seq_d  = seq_q;
      scnt_d = scnt_q;
      case (seq_q)
         POR: begin
            if (scnt_q >= POR_TC) begin
               seq_d  = lvl_nxt[0] ? RUN : BTN;
               scnt_d = '0;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!lvl_nxt[0])
               seq_d = BTN;
         end
         BTN: begin
            if (lvl_nxt[0]) begin
               seq_d  = STRETCH;
               scnt_d = '0;
            end
         end
         STRETCH: begin
            if (!lvl_nxt[0]) begin
               seq_d  = BTN;
               scnt_d = '0;
            end else if (scnt_q >= STR_TC) begin
               seq_d  = RUN;
               scnt_d = '0;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         default: begin
            seq_d  = POR;
            scnt_d = '0;
         end
      endcase
   end

endmodule

// File: doc/button_reset_ctrl.md
Name: button_reset_ctrl

Overview:
- Upstream conditioning stage for the board top: takes raw board push-buttons and produces the clean system reset and control levels that feed the apple1 core (rst_n, vga_cls).
- Per button: 2-flop synchroniser, then a debounce FSM. Generates single-cycle press/release strobes.
- Also contains a power-on/button reset sequencer that holds the system reset low for a guaranteed minimum time.

Parameters:
- NUM_BTN, 2, number of button channels; channel 0 is the reset button.
- DEBOUNCE_CYCLES, 250000, stable cycles required to accept a level change (10 ms at 25 MHz).
- POR_CYCLES, 1000, cycles sys_rst_n is held low after rst_n deasserts.
- RST_STRETCH, 64, minimum low time of sys_rst_n after btn0 debounced release.
- LONG_CYCLES, 25000000, hold time for a long press (optional feature only).

Ports:
- clk25 input 1: 25 MHz system clock.
- rst_n input 1: asynchronous, active-low reset.
- btn_n input NUM_BTN: raw buttons, active-low (0 = pressed), asynchronous.
- btn_level_n output NUM_BTN: debounced level, active-low.
- btn_press output NUM_BTN: 1-cycle strobe on accepted press.
- btn_release output NUM_BTN: 1-cycle strobe on accepted release.
- sys_rst_n output 1: conditioned system reset, active-low.
- btn_long output NUM_BTN: 1-cycle long-press strobe; tied 0 when the feature is absent.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - On rst_n=0, all state clears immediately.
  - Reset values: btn_level_n = all 1s, btn_press = 0, btn_release = 0, btn_long = 0, sys_rst_n = 0.
  - Synchroniser flops reset to 1. FSMs reset to REL. Counters reset to 0.
- Synchroniser: 2 flops per channel. The FSM sees raw input 2 cycles late.
- Debounce FSM per channel, counter width = $clog2(DEBOUNCE_CYCLES+1):
  - REL: level_n = 1. If sync = 0, go to CHK_P with cnt = 1.
  - CHK_P:
    - If sync = 1, return to REL with cnt = 0; no strobe.
    - Else if cnt == DEBOUNCE_CYCLES-1, go to PRS, pulse press, set level_n = 0.
    - Else cnt++.
  - PRS: level_n = 0. If sync = 1, go to CHK_R with cnt = 1.
  - CHK_R: mirror of CHK_P. On acceptance, go to REL, pulse release, set level_n = 1.
  - A glitch shorter than DEBOUNCE_CYCLES produces no level change and no strobe.
  - Latency from stable raw edge to strobe = 2 + DEBOUNCE_CYCLES cycles. The strobe and the level change occur in the same cycle.
- Reset sequencer FSM (states POR, RUN, BTN, STRETCH), counter width = $clog2(max(POR_CYCLES,RST_STRETCH)+1):
  - POR: sys_rst_n = 0. Count POR_CYCLES, then go to RUN. btn0 level is ignored until the count expires. If btn0 is still held when the count expires, go to BTN instead of RUN.
  - RUN: sys_rst_n = 1. If level_n[0] = 0, go to BTN; sys_rst_n falls in the same cycle as the btn0 press strobe is registered.
  - BTN: sys_rst_n = 0. Stay while level_n[0] = 0. On release, go to STRETCH with cnt = 0.
  - STRETCH: sys_rst_n = 0. Count RST_STRETCH cycles, then go to RUN. A re-press during STRETCH returns to BTN.
- Channels ≥1 never affect sys_rst_n.
- The debounce FSMs keep running while sys_rst_n = 0. The top gates other channels with sys_rst_n as needed.
- Simultaneous press on several channels: each channel is independent; strobes may coincide.
- Counters saturate; they never wrap.

Optional Feature:
- Macro BUTTON_LONG_PRESS_EN.
- Defined:
  - A per-channel hold counter runs while in PRS.
  - When it reaches LONG_CYCLES-1, btn_long pulses for 1 cycle.
  - The counter then saturates, so there is one strobe per press.
  - The counter clears on leaving PRS.
- Undefined: no hold counters are instantiated; btn_long is constant 0 and the LONG_CYCLES parameter is unused.

Decomposition:
- Package button_pkg:
  - debounce state encoding (REL, CHK_P, PRS, CHK_R);
  - sequencer state encoding (POR, RUN, BTN, STRETCH);
  - localparam width helpers.
- Sub-module btn_debounce_ch: one channel covering synchroniser, debounce FSM, strobes and the optional long counter. Instantiated NUM_BTN times via generate.
- The sequencer lives in the top of this block.

Test Plan (DEBOUNCE_CYCLES=8, POR_CYCLES=20, RST_STRETCH=5, LONG_CYCLES=30):
- Reset release, buttons idle -> sys_rst_n low for exactly 20 cycles, then 1; btn_level_n = 2'b11; no strobes.
- btn_n[1] low for 5 cycles, then high (glitch) -> no press strobe; btn_level_n[1] stays 1.
- btn_n[1] low and held -> btn_press[1] pulses exactly 10 cycles after the edge; level_n[1] = 0. Release held high -> btn_release[1] pulses 10 cycles after the edge.
- In RUN, btn0 pressed 40 cycles then released -> sys_rst_n falls 10 cycles after press; rises 10+5 cycles after the release edge.
- btn0 held through POR -> sys_rst_n stays 0 continuously; the sequencer reaches STRETCH only after release.
- BUTTON_LONG_PRESS_EN defined, btn1 held 60 cycles -> exactly one btn_long[1] strobe, 30 cycles after the press strobe. Without the macro -> btn_long stays 0.
- Assert rst_n mid-debounce (CHK_P) -> outputs return to reset values immediately; no strobe after deassertion unless the input is held low.
